alu: RTL and testbench

- Registered 4-function unsigned integer ALU: add, subtract, multiply and divide of two 32-bit operands.
- Result is truncated to a 16-bit output.
- Sits in the datapath as the single arithmetic unit; the operation is chosen each cycle by a 2-bit selector.
- Output is registered, so consumers see the result one clock after operands/select are sampled.

---
 rtl/alu.sv | 79 +++++++
 tb/tb_alu.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered 4-function unsigned ALU: 32-bit operands, result truncated to 16 bits, one cycle latency.
// Optional registered ALU_Zero/ALU_Ovf flag outputs are enabled by defining ALU_FLAGS_EN.
module alu (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  ALU_Sel,
    output logic [15:0] ALU_Out
`ifdef ALU_FLAGS_EN
    ,
    output logic        ALU_Zero,
    output logic        ALU_Ovf
`endif
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    op_t         op;
    logic [15:0] res;

    assign op = op_t'(ALU_Sel);

    // Low 16 bits of add/sub/mul depend only on the operands' low halves.
    always_comb begin
        res = '0;
        case (op)
            OP_ADD: res = A[15:0] + B[15:0];
            OP_SUB: res = A[15:0] - B[15:0];
            OP_MUL: res = A[15:0] * B[15:0];
            OP_DIV: res = (B == '0) ? 16'hFFFF : 16'(A / B);
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ALU_Out <= '0;
        else       ALU_Out <= res;
    end

`ifdef ALU_FLAGS_EN
    logic        ovf;
    logic [32:0] sum;
    logic [31:0] diff;
    logic [63:0] prod;

    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = A - B;
    assign prod = {32'b0, A} * {32'b0, B};

    // Quotient exceeds 16 bits exactly when A >= B * 2^16, i.e. A[31:16] >= B.
    always_comb begin
        ovf = 1'b0;
        case (op)
            OP_ADD: ovf = (sum > 33'h0_0000_FFFF);
            OP_SUB: ovf = (A < B) || (diff > 32'h0000_FFFF);
            OP_MUL: ovf = (prod > 64'h0000_0000_0000_FFFF);
            OP_DIV: ovf = (B == '0) || ({16'b0, A[31:16]} >= B);
            default: ovf = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ALU_Zero <= 1'b0;
            ALU_Ovf  <= 1'b0;
        end else begin
            ALU_Zero <= (res == '0);
            ALU_Ovf  <= ovf;
        end
    end
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: reset behaviour, directed vector table, mid-stream reset, random back-to-back ops.
module tb_alu;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  ALU_Sel;
    logic [15:0] ALU_Out;
`ifdef ALU_FLAGS_EN
    logic        ALU_Zero;
    logic        ALU_Ovf;
`endif

    int unsigned n_pass;
    int unsigned n_total;

    alu dut (
        .clk     (clk),
        .reset   (reset),
        .A       (A),
        .B       (B),
        .ALU_Sel (ALU_Sel),
        .ALU_Out (ALU_Out)
`ifdef ALU_FLAGS_EN
        ,
        .ALU_Zero(ALU_Zero),
        .ALU_Ovf (ALU_Ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  sel;
        logic [15:0] out;
        logic        zero;
        logic        ovf;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic check_all(input string name, input logic [15:0] exp_out,
                             input logic exp_zero, input logic exp_ovf);
        check(name, ALU_Out, exp_out);
`ifdef ALU_FLAGS_EN
        check({name, "_zero"}, {15'b0, ALU_Zero}, {15'b0, exp_zero});
        check({name, "_ovf"},  {15'b0, ALU_Ovf},  {15'b0, exp_ovf});
`else
        if (exp_zero === 1'bx || exp_ovf === 1'bx) $display("note: unknown flag expectation in %s", name);
`endif
    endtask

    function automatic logic [63:0] model_full(input logic [31:0] a, input logic [31:0] b,
                                               input logic [1:0] sel);
        logic [63:0] f;
        case (sel)
            2'b00: f = {32'b0, a} + {32'b0, b};
            2'b01: f = {32'b0, a - b};
            2'b10: f = {32'b0, a} * {32'b0, b};
            default: f = (b == 0) ? 64'hFFFF : {32'b0, a / b};
        endcase
        return f;
    endfunction

    function automatic logic model_ovf(input logic [31:0] a, input logic [31:0] b,
                                       input logic [1:0] sel);
        logic [63:0] f;
        f = model_full(a, b, sel);
        if (sel == 2'b11 && b == 0) return 1'b1;
        if (sel == 2'b01 && a < b) return 1'b1;
        return (f > 64'hFFFF);
    endfunction

    initial begin
        n_pass  = 0;
        n_total = 0;

        vecs[0]  = '{32'h0000_00FA, 32'h0000_0002, 2'b01, 16'h00F8, 1'b0, 1'b0};
        vecs[1]  = '{32'h0000_00FA, 32'h0000_0002, 2'b10, 16'h01F4, 1'b0, 1'b0};
        vecs[2]  = '{32'h0000_00FA, 32'h0000_0002, 2'b11, 16'h007D, 1'b0, 1'b0};
        vecs[3]  = '{32'h0000_00FA, 32'h0000_0002, 2'b00, 16'h00FC, 1'b0, 1'b0};
        vecs[4]  = '{32'h0000_FFFF, 32'h0000_0001, 2'b00, 16'h0000, 1'b1, 1'b1};
        vecs[5]  = '{32'h0000_0001, 32'h0000_0002, 2'b01, 16'hFFFF, 1'b0, 1'b1};
        vecs[6]  = '{32'h0000_1234, 32'h0000_0100, 2'b10, 16'h3400, 1'b0, 1'b1};
        vecs[7]  = '{32'h0000_0005, 32'h0000_0000, 2'b11, 16'hFFFF, 1'b0, 1'b1};
        vecs[8]  = '{32'h0000_0007, 32'h0000_0002, 2'b11, 16'h0003, 1'b0, 1'b0};
        vecs[9]  = '{32'h0003_0000, 32'h0000_0001, 2'b11, 16'h0000, 1'b1, 1'b1};
        vecs[10] = '{32'h0000_0000, 32'h0000_0000, 2'b00, 16'h0000, 1'b1, 1'b0};
        vecs[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 16'hFFFE, 1'b0, 1'b1};
        vecs[12] = '{32'h0001_0000, 32'h0000_0001, 2'b01, 16'hFFFF, 1'b0, 1'b0};
        vecs[13] = '{32'h0000_0000, 32'hFFFF_FFFF, 2'b01, 16'h0001, 1'b0, 1'b1};
        vecs[14] = '{32'h0000_FFFF, 32'h0000_0001, 2'b10, 16'hFFFF, 1'b0, 1'b0};
        vecs[15] = '{32'h0001_0000, 32'h0000_0001, 2'b10, 16'h0000, 1'b1, 1'b1};

        // Reset held with clock running: output stays cleared.
        reset   = 1'b1;
        A       = 32'h0000_00FA;
        B       = 32'h0000_0002;
        ALU_Sel = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset_hold%0d", i), ALU_Out, 16'h0000);
        end

        // First update on the first edge after deassertion.
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_all("first_after_reset", 16'h01F4, 1'b0, 1'b0);

        // Directed table, one vector per cycle.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            A       = vecs[i].a;
            B       = vecs[i].b;
            ALU_Sel = vecs[i].sel;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].out, vecs[i].zero, vecs[i].ovf);
        end

        // Asynchronous reset mid-cycle clears before the next edge.
        @(negedge clk);
        A       = 32'h0000_0001;
        B       = 32'h0000_0002;
        ALU_Sel = 2'b01;
        @(posedge clk);
        #1;
        check_all("pre_async_reset", 16'hFFFF, 1'b0, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check_all("async_reset", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Random back-to-back operations, no bubbles.
        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic [1:0]  rs;
            logic [63:0] f;
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : $urandom_range(0, 300);
            rs = 2'($urandom_range(0, 3));
            f  = model_full(ra, rb, rs);
            A       = ra;
            B       = rb;
            ALU_Sel = rs;
            @(posedge clk);
            #1;
            check_all($sformatf("rand%0d", i), f[15:0], (f[15:0] == 16'h0000), model_ovf(ra, rb, rs));
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
